// File: rtl/game_pkg.sv
// Shared game definitions: state encoding used by the FSM and the display mux.
package game_pkg;

  typedef enum logic [1:0] {
    ST_START    = 2'b00,
    ST_GAME     = 2'b01,
    ST_GAMEOVER = 2'b10
  } game_state_t;

  localparam int HOLD_FRAMES_DEFAULT = 60;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for the raw button plus a rising-edge detector.
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic btn_rise
);

  logic       sync_p0;
  logic       sync_p1;
  logic       prev_p2;
  logic [2:0] vld_p;

  // Stage p0/p1: metastability filter; p2: previous synchronized level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
      vld_p   <= 3'b000;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
      vld_p   <= {vld_p[1:0], 1'b1};
    end
  end

  // Edges are only trusted once both compared stages hold post-reset samples,
  // so a button already held at reset release never looks like a press.
  assign btn_rise = vld_p[2] & sync_p1 & ~prev_p2;

endmodule

// File: rtl/game_fsm.sv
// Top-level game state machine: START -> GAME -> GAMEOVER, advancing on frame ticks.
module game_fsm
  import game_pkg::*;
#(
  parameter int HOLD_FRAMES = HOLD_FRAMES_DEFAULT,
  parameter int HOLD_W      = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  input  logic       collision,
  input  logic       frame_tick,
  output logic [1:0] state,
  output logic       game_rst,
  output logic       jump,
  output logic       hold_active
);

  game_state_t       state_q;
  game_state_t       state_d;
  logic              pend_q;
  logic              pend_d;
  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_d;
  logic              game_rst_d;
  logic              jump_d;
  logic              btn_rise;
  logic              evt;
  logic              adv;
  logic              hold_zero;

  btn_sync_edge u_btn (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn      (btn),
    .btn_rise (btn_rise)
  );

  assign hold_zero = (hold_q == '0);
  assign state     = state_q;

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    hold_d     = hold_q;
    game_rst_d = 1'b0;
    jump_d     = 1'b0;
    evt        = 1'b0;
    adv        = 1'b0;
    case (state_q)
      ST_START: begin
        evt = btn_rise;
        adv = (pend_q | evt) & frame_tick;
        if (adv) begin
          state_d    = ST_GAME;
          game_rst_d = 1'b1;
        end
      end
      ST_GAME: begin
        evt    = collision;
        jump_d = btn_rise;
        adv    = (pend_q | evt) & frame_tick;
        if (adv) begin
          state_d = ST_GAMEOVER;
          hold_d  = HOLD_W'(HOLD_FRAMES);
        end
      end
      ST_GAMEOVER: begin
        evt = btn_rise & hold_zero;
        adv = (pend_q | evt) & frame_tick;
        if (adv) begin
          state_d = ST_START;
        end else if (frame_tick && !hold_zero) begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      default: begin
        state_d = ST_START;
        hold_d  = '0;
      end
    endcase
    // A pending request never survives a transition or an illegal state
    if (adv || (state_q != ST_START && state_q != ST_GAME && state_q != ST_GAMEOVER))
      pend_d = 1'b0;
    else if (evt)
      pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_START;
      pend_q      <= 1'b0;
      hold_q      <= '0;
      game_rst    <= 1'b0;
      jump        <= 1'b0;
      hold_active <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      hold_q      <= hold_d;
      game_rst    <= game_rst_d;
      jump        <= jump_d;
      hold_active <= (hold_d != '0);
    end
  end

endmodule

// File: tb/tb_game_fsm.sv
// Randomized and directed bench for game_fsm against a frame-level behavioural model.
module tb_game_fsm;
  import game_pkg::*;

  localparam int HF = 4;
  localparam int HW = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn = 1'b0;
  logic       collision = 1'b0;
  logic       frame_tick = 1'b0;
  logic [1:0] state;
  logic       game_rst;
  logic       jump;
  logic       hold_active;

  int n_tests = 0;
  int n_fail  = 0;
  int jump_cnt = 0;

  // model: game phase 0/1/2 (3 = corrupted), pending request, frames left in hold
  int m_st, m_hold, m_edges;
  bit m_pend, m_jump, m_grst;
  bit h0, h1, h2;

  always #5 clk = ~clk;

  game_fsm #(.HOLD_FRAMES(HF), .HOLD_W(HW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn         (btn),
    .collision   (collision),
    .frame_tick  (frame_tick),
    .state       (state),
    .game_rst    (game_rst),
    .jump        (jump),
    .hold_active (hold_active)
  );

  always @(negedge clk)
    assert (state != 2'b11) else $error("illegal state value on output");

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected normal end");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_hold = 0; m_edges = 0;
    m_pend = 0; m_jump = 0; m_grst = 0;
    h0 = 0; h1 = 0; h2 = 0;
  endtask

  // A press counts when the button was low two samples earlier and high one sample
  // earlier, once three post-reset samples exist.
  task automatic model_step();
    bit rise, ev, go;
    if (m_edges < 10) m_edges++;
    rise = (m_edges >= 4) && h1 && !h2;
    h2 = h1; h1 = h0; h0 = btn;
    m_jump = 0; m_grst = 0;
    if (m_st == 3) begin
      m_st = 0; m_pend = 0; m_hold = 0;
      return;
    end
    ev = (m_st == 0 && rise) || (m_st == 1 && collision) || (m_st == 2 && rise && m_hold == 0);
    go = (m_pend || ev) && frame_tick;
    m_jump = (m_st == 1) && rise;
    if (go) begin
      m_grst = (m_st == 0);
      if (m_st == 1) m_hold = HF;
      m_st = (m_st + 1) % 3;
      m_pend = 0;
    end else begin
      if (ev) m_pend = 1;
      if (m_st == 2 && frame_tick && m_hold > 0) m_hold--;
    end
  endtask

  task automatic compare();
    chk("state", state, m_st);
    chk("game_rst", game_rst, m_grst);
    chk("jump", jump, m_jump);
    chk("hold_active", hold_active, (m_hold != 0));
  endtask

  task automatic cycle(input bit b, input bit c, input bit t);
    btn = b; collision = c; frame_tick = t;
    @(posedge clk);
    if (rst_n) model_step(); else model_reset();
    @(negedge clk);
    compare();
    jump_cnt += int'(jump);
  endtask

  task automatic press_then_tick();
    repeat (2) cycle(1, 0, 0);
    repeat (3) cycle(0, 0, 0);
    cycle(0, 0, 1);
  endtask

  task automatic async_reset(input bit b);
    #2 rst_n = 1'b0; btn = b;
    #1 model_reset();
    compare();
    repeat (2) cycle(b, 0, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    bit rb;
    model_reset();
    @(negedge clk);
    compare();
    repeat (2) cycle(0, 0, 0);
    rst_n = 1'b1;

    // idle frames in START
    repeat (5) begin
      repeat (3) cycle(0, 0, 0);
      cycle(0, 0, 1);
    end
    chk("start_idle", state, 0);

    // press mid-frame then tick
    repeat (4) cycle(1, 0, 0);
    repeat (2) cycle(0, 0, 0);
    cycle(0, 0, 1);
    chk("to_game", state, 1);
    chk("game_rst_pulse", game_rst, 1);
    chk("no_jump_on_start", jump, 0);
    cycle(0, 0, 0);
    chk("game_rst_width", game_rst, 0);

    // three separate presses in GAME
    jump_cnt = 0;
    repeat (3) begin
      repeat (3) cycle(1, 0, 0);
      repeat (4) cycle(0, 0, 0);
    end
    chk("jump_count", jump_cnt, 3);
    chk("game_stays", state, 1);

    cycle(0, 1, 1);
    chk("to_gameover", state, 2);
    chk("hold_loaded", hold_active, 1);

    for (int i = 1; i <= 3; i++) begin
      press_then_tick();
      chk("hold_ignores_press", state, 2);
      chk("hold_active_frames", hold_active, 1);
    end
    repeat (2) cycle(0, 0, 0);
    cycle(0, 0, 1);
    chk("hold_expired", hold_active, 0);
    chk("gameover_stays", state, 2);
    press_then_tick();
    chk("back_to_start", state, 0);

    // reset with a pending collision, then release with the button held
    press_then_tick();
    chk("regame", state, 1);
    cycle(0, 1, 0);
    #2 rst_n = 1'b0; btn = 1'b1;
    #1 model_reset();
    chk("rst_state", state, 0);
    chk("rst_game_rst", game_rst, 0);
    chk("rst_jump", jump, 0);
    chk("rst_hold", hold_active, 0);
    repeat (2) cycle(1, 0, 0);
    rst_n = 1'b1;
    repeat (3) begin
      repeat (3) cycle(1, 0, 0);
      cycle(1, 0, 1);
    end
    chk("held_btn_no_start", state, 0);
    repeat (3) cycle(0, 0, 0);

    // corrupted state register recovers
    #1 force dut.state_q = game_state_t'(2'b11);
    #1 release dut.state_q;
    m_st = 3;
    cycle(0, 0, 0);
    chk("illegal_recover", state, 0);

    // randomized play
    rb = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(5) == 0) rb = ~rb;
      if ($urandom_range(599) == 0) async_reset(rb);
      cycle(rb, ($urandom_range(15) == 0), ($urandom_range(7) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/game_fsm.md
GAME_FSM -- requirements
Module: game_fsm

Interface
REQ-001 Parameter HOLD_FRAMES, default 60: number of frames after entering GAMEOVER during which the button is ignored.
REQ-002 Parameter HOLD_W, default 7: width of the hold counter; it SHALL satisfy 2^HOLD_W > HOLD_FRAMES.
REQ-003 clk  in  1: single system clock (pixel clock domain).
REQ-004 rst_n  in  1: asynchronous, active-low reset.
REQ-005 btn  in  1: raw player button, asynchronous to clk.
REQ-006 collision  in  1: level, high while the bird overlaps a pipe or a screen edge; synchronous to clk.
REQ-007 frame_tick  in  1: one-cycle pulse at the start of vertical blanking.
REQ-008 state  out  2: game state driving the display mux (START=2'b00, GAME=2'b01, GAMEOVER=2'b10), registered.
REQ-009 game_rst  out  1: one-cycle pulse that clears bird, pipes and score, registered.
REQ-010 jump  out  1: one-cycle pulse per button press while in GAME, registered.
REQ-011 hold_active  out  1: high while the GAMEOVER hold counter is nonzero, registered.

Function
REQ-012 btn SHALL pass through a 2-flop synchronizer; a rising edge of the second stage SHALL form the internal one-cycle signal btn_rise.
REQ-013 States: START, GAME, GAMEOVER; the encoding 2'b11 SHALL never be output, and if it is reached it SHALL return to START on the next clock.
REQ-014 START: btn_rise SHALL set pend.
REQ-015 GAME: collision=1 SHALL set pend; btn_rise SHALL NOT set pend.
REQ-016 GAMEOVER: btn_rise SHALL set pend only when the hold counter is 0.
REQ-017 In all other states, the collision and btn_rise events listed above SHALL be ignored.
REQ-018 Transitions SHALL occur only on frame_tick: when (pend | qualifying event in the same cycle) and frame_tick are both 1, state SHALL advance at that clock edge (START->GAME, GAME->GAMEOVER, GAMEOVER->START), and pend SHALL clear.
REQ-019 Event and frame_tick in the same cycle SHALL transition at that tick; pend SHALL NOT carry over to the next state.
REQ-020 game_rst SHALL be 1 for exactly the first cycle in which state==GAME after START->GAME; it SHALL be 0 otherwise.
REQ-021 jump SHALL be 1 in the cycle after btn_rise when state==GAME at btn_rise; it SHALL be 0 otherwise (including the press that caused START->GAME).
REQ-022 On entry to GAMEOVER the hold counter SHALL load HOLD_FRAMES; it SHALL decrement by 1 on each frame_tick while in GAMEOVER and >0, saturating at 0.
REQ-023 hold_active SHALL equal (counter != 0).
REQ-024 Button latency: a press SHALL be recognized no earlier than 3 clocks after btn rises; a held button SHALL generate exactly one btn_rise.

Reset
REQ-025 rst_n=0 SHALL asynchronously force: state=START, pend=0, hold counter=0, game_rst=0, jump=0, hold_active=0, synchronizer flops=0.
REQ-026 Reset asserted mid-game SHALL discard any pending transition; after release, operation SHALL resume at START, and the first frame_tick SHALL cause no transition unless a new press occurred.
REQ-027 Reset release SHALL NOT produce a btn_rise if btn is already high.

Structure
REQ-028 Package game_pkg SHALL hold the state enum type (game_state_t: ST_START, ST_GAME, ST_GAMEOVER) and the default HOLD_FRAMES constant; the display mux and this block SHALL both import it.
REQ-029 One sub-module, btn_sync_edge (2-flop synchronizer + rising-edge detector, async active-low reset), SHALL be instantiated; all else SHALL be flat.

Verification
REQ-030 Reset release, btn=0, 5 frame_ticks -> state stays 2'b00, game_rst=0 throughout.
REQ-031 In START, press btn mid-frame, then frame_tick -> state=2'b01 on the tick edge, game_rst=1 for one cycle, jump=0.
REQ-032 In GAME, 3 separate presses -> exactly 3 jump pulses, each 1 cycle, state unchanged; collision pulse + frame_tick in the same cycle -> state=2'b10 at that edge.
REQ-033 In GAMEOVER with HOLD_FRAMES=4: press at frames 1-3 -> ignored, hold_active=1; after the 4th tick hold_active=0; then press + tick -> state=2'b00.
REQ-034 Assert rst_n=0 with pend set in GAME -> immediate state=2'b00, outputs 0; after release with btn held high, ticks -> no transition.
REQ-035 Force the state register to 2'b11 -> state=2'b00 after one clock; assertion: state!=2'b11 at all outputs.
